pc_reg_redirect: RTL and testbench

Parametrised program-counter / fetch-enable block, the next-generation PC stage of the pipelined CPU. It generates the fetch address and the instruction-memory enable. It adds a configurable reset vector and step, a pipeline stall hold, and branch/jump redirection. Branches that arrive during a stall are buffered and applied when the stall releases. An exception/flush redirect takes priority over everything else.

---
 rtl/pc_reg_redirect.sv | 60 ++++++
 tb/tb_pc_reg_redirect.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_reg_redirect.sv
// Program counter / fetch-enable stage with stall hold, buffered branch
// redirection during stalls, and highest-priority flush redirection.
module pc_reg_redirect #(
    parameter int unsigned          ADDR_W       = 32,
    parameter logic [ADDR_W-1:0]    RESET_VECTOR = '0,
    parameter int unsigned          STEP         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_flag,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              ce,
    output logic              redirect
);

    localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);

    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_VECTOR;
            ce          <= 1'b0;
            redirect    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else if (!ce) begin
            // First active edge only enables fetch so RESET_VECTOR is fetched first.
            ce       <= 1'b1;
            redirect <= 1'b0;
        end else if (flush) begin
            pc         <= new_pc;
            pend_valid <= 1'b0;
            redirect   <= 1'b1;
        end else if (stall) begin
            redirect <= 1'b0;
            if (branch_flag) begin
                pend_target <= branch_target;
                pend_valid  <= 1'b1;
            end
        end else if (branch_flag) begin
            pc         <= branch_target;
            pend_valid <= 1'b0;
            redirect   <= 1'b1;
        end else if (pend_valid) begin
            pc         <= pend_target;
            pend_valid <= 1'b0;
            redirect   <= 1'b1;
        end else begin
            pc       <= pc + STEP_INC;
            redirect <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_reg_redirect.sv
// Self-checking bench for pc_reg_redirect: directed scenarios with fixed
// expectations plus randomized traffic against a queue-based reference model.
module tb_pc_reg_redirect;

    localparam logic [31:0] RV   = 32'hBFC00000;
    localparam int unsigned STEP = 4;

    logic        clk = 1'b0;
    logic        rst, stall, branch_flag, flush;
    logic [31:0] branch_target, new_pc;
    logic [31:0] pc;
    logic        ce, redirect;

    int unsigned total  = 0;
    int unsigned passed = 0;

    // reference model state
    logic [31:0] m_pc;
    bit          m_ce, m_red;
    logic [31:0] m_pend[$];

    typedef struct {
        bit          r, fl, st, br;
        logic [31:0] bt, np, epc;
        bit          ece, ered;
    } vec_t;

    pc_reg_redirect #(
        .ADDR_W(32),
        .RESET_VECTOR(RV),
        .STEP(STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .branch_flag(branch_flag),
        .branch_target(branch_target),
        .flush(flush),
        .new_pc(new_pc),
        .pc(pc),
        .ce(ce),
        .redirect(redirect)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(bit r, bit fl, bit st, bit br, logic [31:0] bt,
                                logic [31:0] np, logic [31:0] epc, bit ece, bit ered);
        vec_t v;
        v.r = r; v.fl = fl; v.st = st; v.br = br; v.bt = bt; v.np = np;
        v.epc = epc; v.ece = ece; v.ered = ered;
        return v;
    endfunction

    task automatic apply(vec_t v);
        rst = v.r; flush = v.fl; stall = v.st; branch_flag = v.br;
        branch_target = v.bt; new_pc = v.np;
    endtask

    // Advance the model from the inputs about to be sampled, then cross the edge.
    task automatic tick();
        if (rst) begin
            m_pc = RV; m_ce = 0; m_red = 0; m_pend.delete();
        end else if (!m_ce) begin
            m_ce = 1; m_red = 0;
        end else if (flush) begin
            m_pc = new_pc; m_red = 1; m_pend.delete();
        end else if (stall) begin
            m_red = 0;
            if (branch_flag) begin
                m_pend.delete();
                m_pend.push_back(branch_target);
            end
        end else if (branch_flag) begin
            m_pc = branch_target; m_red = 1; m_pend.delete();
        end else if (m_pend.size() != 0) begin
            m_pc = m_pend.pop_front(); m_red = 1;
        end else begin
            m_pc = m_pc + 32'(STEP); m_red = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v[$];
        v.push_back(mk(1,0,0,0,0,0, RV,           0,0));
        v.push_back(mk(1,1,1,1,32'h44,32'h55, RV, 0,0));
        v.push_back(mk(0,1,0,1,32'h44,32'h55, RV, 1,0));
        v.push_back(mk(0,0,0,0,0,0, RV+32'd4,     1,0));
        v.push_back(mk(0,0,0,0,0,0, RV+32'd8,     1,0));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]); tick(); total++;
            if (pc !== v[i].epc || ce !== v[i].ece || redirect !== v[i].ered)
                $display("FAIL reset[%0d]: got pc=%h ce=%b redirect=%b, want pc=%h ce=%b redirect=%b",
                         i, pc, ce, redirect, v[i].epc, v[i].ece, v[i].ered);
            else passed++;
        end
    endtask

    task automatic test_branch();
        vec_t v[$];
        v.push_back(mk(0,1,0,0,0,32'h0,   32'h0,   1,1));
        v.push_back(mk(0,0,0,0,0,0,       32'h4,   1,0));
        v.push_back(mk(0,0,0,0,0,0,       32'h8,   1,0));
        v.push_back(mk(0,0,0,0,0,0,       32'hC,   1,0));
        v.push_back(mk(0,0,0,0,0,0,       32'h10,  1,0));
        v.push_back(mk(0,0,0,1,32'h100,0, 32'h100, 1,1));
        v.push_back(mk(0,0,0,0,0,0,       32'h104, 1,0));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]); tick(); total++;
            if (pc !== v[i].epc || ce !== v[i].ece || redirect !== v[i].ered)
                $display("FAIL branch[%0d]: got pc=%h ce=%b redirect=%b, want pc=%h ce=%b redirect=%b",
                         i, pc, ce, redirect, v[i].epc, v[i].ece, v[i].ered);
            else passed++;
        end
    endtask

    task automatic test_stall_buffer();
        vec_t v[$];
        v.push_back(mk(0,1,0,0,0,32'h20,  32'h20,  1,1));
        v.push_back(mk(0,0,1,1,32'h200,0, 32'h20,  1,0));
        v.push_back(mk(0,0,1,1,32'h300,0, 32'h20,  1,0));
        v.push_back(mk(0,0,1,0,0,0,       32'h20,  1,0));
        v.push_back(mk(0,0,0,0,0,0,       32'h300, 1,1));
        v.push_back(mk(0,0,0,0,0,0,       32'h304, 1,0));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]); tick(); total++;
            if (pc !== v[i].epc || ce !== v[i].ece || redirect !== v[i].ered)
                $display("FAIL stall_buffer[%0d]: got pc=%h ce=%b redirect=%b, want pc=%h ce=%b redirect=%b",
                         i, pc, ce, redirect, v[i].epc, v[i].ece, v[i].ered);
            else passed++;
        end
    endtask

    task automatic test_flush_stall();
        vec_t v[$];
        v.push_back(mk(0,1,0,0,0,32'h1000, 32'h1000, 1,1));
        v.push_back(mk(0,0,1,1,32'h400,0,  32'h1000, 1,0));
        v.push_back(mk(0,1,1,0,0,32'h80,   32'h80,   1,1));
        v.push_back(mk(0,0,1,0,0,0,        32'h80,   1,0));
        v.push_back(mk(0,0,0,0,0,0,        32'h84,   1,0));
        v.push_back(mk(0,0,0,0,0,0,        32'h88,   1,0));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]); tick(); total++;
            if (pc !== v[i].epc || ce !== v[i].ece || redirect !== v[i].ered)
                $display("FAIL flush_stall[%0d]: got pc=%h ce=%b redirect=%b, want pc=%h ce=%b redirect=%b",
                         i, pc, ce, redirect, v[i].epc, v[i].ece, v[i].ered);
            else passed++;
        end
    endtask

    task automatic test_flush_branch();
        vec_t v[$];
        v.push_back(mk(0,1,0,1,32'h500,32'h180, 32'h180, 1,1));
        v.push_back(mk(0,0,1,1,32'h700,0,       32'h180, 1,0));
        v.push_back(mk(0,0,0,1,32'h600,0,       32'h600, 1,1));
        v.push_back(mk(0,0,0,0,0,0,             32'h604, 1,0));
        v.push_back(mk(0,0,0,0,0,0,             32'h608, 1,0));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]); tick(); total++;
            if (pc !== v[i].epc || ce !== v[i].ece || redirect !== v[i].ered)
                $display("FAIL flush_branch[%0d]: got pc=%h ce=%b redirect=%b, want pc=%h ce=%b redirect=%b",
                         i, pc, ce, redirect, v[i].epc, v[i].ece, v[i].ered);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        v.push_back(mk(0,0,0,1,32'h2000,0,       32'h2000, 1,1));
        v.push_back(mk(0,0,0,1,32'h3000,0,       32'h3000, 1,1));
        v.push_back(mk(0,1,0,0,0,32'h4000,       32'h4000, 1,1));
        v.push_back(mk(0,0,0,1,32'h4004,0,       32'h4004, 1,1));
        v.push_back(mk(0,0,0,0,0,0,              32'h4008, 1,0));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]); tick(); total++;
            if (pc !== v[i].epc || ce !== v[i].ece || redirect !== v[i].ered)
                $display("FAIL back_to_back[%0d]: got pc=%h ce=%b redirect=%b, want pc=%h ce=%b redirect=%b",
                         i, pc, ce, redirect, v[i].epc, v[i].ece, v[i].ered);
            else passed++;
        end
    endtask

    task automatic test_wrap_reset();
        vec_t v[$];
        v.push_back(mk(0,1,0,0,0,32'hFFFFFFF8, 32'hFFFFFFF8, 1,1));
        v.push_back(mk(0,0,0,0,0,0,            32'hFFFFFFFC, 1,0));
        v.push_back(mk(0,0,0,0,0,0,            32'h00000000, 1,0));
        v.push_back(mk(0,0,0,0,0,0,            32'h00000004, 1,0));
        v.push_back(mk(0,0,1,1,32'h900,0,      32'h00000004, 1,0));
        v.push_back(mk(1,0,1,0,0,0,            RV,           0,0));
        v.push_back(mk(0,0,1,0,0,0,            RV,           1,0));
        v.push_back(mk(0,0,0,0,0,0,            RV+32'd4,     1,0));
        v.push_back(mk(0,0,0,0,0,0,            RV+32'd8,     1,0));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]); tick(); total++;
            if (pc !== v[i].epc || ce !== v[i].ece || redirect !== v[i].ered)
                $display("FAIL wrap_reset[%0d]: got pc=%h ce=%b redirect=%b, want pc=%h ce=%b redirect=%b",
                         i, pc, ce, redirect, v[i].epc, v[i].ece, v[i].ered);
            else passed++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(63) == 0);
            flush         = ($urandom_range(15) == 0);
            stall         = ($urandom_range(2) == 0);
            branch_flag   = ($urandom_range(3) == 0);
            branch_target = $urandom();
            new_pc        = ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15)))
                                                     : $urandom();
            tick(); total++;
            if (pc !== m_pc || ce !== m_ce || redirect !== m_red)
                $display("FAIL random[%0d]: got pc=%h ce=%b redirect=%b, want pc=%h ce=%b redirect=%b",
                         i, pc, ce, redirect, m_pc, m_ce, m_red);
            else passed++;
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; flush = 1'b0;
        branch_target = '0; new_pc = '0;
        m_pc = RV; m_ce = 0; m_red = 0;
        test_reset();
        test_branch();
        test_stall_buffer();
        test_flush_stall();
        test_flush_branch();
        test_back_to_back();
        test_wrap_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
